// File: rtl/prim_shadow_wr_seq.sv
// prim_shadow_wr_seq
//   Hardware write sequencer placed in front of a shadowed register slice.
//   Turns one write request into the phase-clear / first write / optional gap /
//   second write sequence and returns a status word over a req/ack handshake.
//
// Ports
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   req_i           write request (level, sampled only when idle)
//   wdata_i         write data, captured on accept
//   ack_o           one-cycle completion pulse
//   busy_o          high whenever a transaction is in flight
//   status_o        valid with ack_o: [0] update err, [1] readback mismatch,
//                   [2] storage err; zero whenever ack_o is low
//   fatal_o         sticky storage-error flag, cleared only by reset
//   re_o/we_o/wd_o  drive the slice re/we/wd inputs
//   err_update_i, err_storage_i, qs_i   slice observation inputs
//
// State table
//   state   | meaning
//   IDLE    | waiting for req_i; accept captures data and clears status
//   CLEAR   | re_o pulse to force the slice phase back to 0
//   WR1     | first write (we_o)
//   GAP     | idle cycles between the two writes (down-counter)
//   WR2     | second write (we_o), err_update_i sampled
//   CHECK   | compare qs_i against captured data
//   DONE    | ack_o pulse with status_o, back to IDLE

module prim_shadow_wr_seq #(
  parameter int unsigned DW            = 32,
  parameter int unsigned GapCycles     = 0,
  parameter bit          CheckReadback = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_i,
  input  logic [DW-1:0] wdata_i,
  output logic          ack_o,
  output logic          busy_o,
  output logic [2:0]    status_o,
  output logic          fatal_o,
  output logic          re_o,
  output logic          we_o,
  output logic [DW-1:0] wd_o,
  input  logic          err_update_i,
  input  logic          err_storage_i,
  input  logic [DW-1:0] qs_i
);

  if (GapCycles > 15) begin : gen_gap_range_err
    $error("GapCycles must be within 0..15");
  end

  localparam logic [3:0] GapLoad = (GapCycles > 0) ? 4'(GapCycles - 1) : 4'd0;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StWr1,
    StGap,
    StWr2,
    StCheck,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [3:0]    gap_q, gap_d;
  logic [2:0]    status_q, status_d;
  logic          fatal_q, fatal_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      data_q   <= '0;
      gap_q    <= '0;
      status_q <= '0;
      fatal_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      gap_q    <= gap_d;
      status_q <= status_d;
      fatal_q  <= fatal_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    gap_d    = gap_q;
    status_d = status_q;
    fatal_d  = fatal_q | err_storage_i;

    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          data_d   = wdata_i;
          status_d = '0;
          // Once storage is known bad, refuse to touch the slice again.
          if (fatal_q) begin
            status_d = 3'b100;
            state_d  = StDone;
          end else begin
            state_d  = StClear;
          end
        end
      end
      StClear: state_d = StWr1;
      StWr1: begin
        if (GapCycles > 0) begin
          gap_d   = GapLoad;
          state_d = StGap;
        end else begin
          state_d = StWr2;
        end
      end
      StGap: begin
        if (gap_q != 4'd0) gap_d = gap_q - 4'd1;
        else               state_d = StWr2;
      end
      StWr2: begin
        // err_update is combinational on we, so it is valid in this cycle.
        status_d[0] = err_update_i;
        state_d     = StCheck;
      end
      StCheck: begin
        if (CheckReadback && (qs_i != data_q)) status_d[1] = 1'b1;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Storage corruption aborts the sequence without any further strobes.
    if (err_storage_i && (state_q != StIdle) && (state_q != StDone)) begin
      status_d[2] = 1'b1;
      state_d     = StDone;
    end
  end

  assign ack_o    = (state_q == StDone);
  assign busy_o   = (state_q != StIdle);
  assign re_o     = (state_q == StClear);
  assign we_o     = (state_q == StWr1) || (state_q == StWr2);
  assign wd_o     = we_o ? data_q : '0;
  assign status_o = ack_o ? status_q : 3'b000;
  assign fatal_o  = fatal_q;

endmodule

// File: doc/prim_shadow_wr_seq.md
Name: prim_shadow_wr_seq

Overview:
- Hardware write sequencer that sits directly upstream of a shadowed register slice. It drives that slice's re/we/wd inputs.
- Converts one single-shot write request from a hardware master into the required phase-clear, first write, optional gap and second write sequence.
- Samples the slice's err_update/err_storage/qs outputs and returns one status word per request over a req/ack handshake.
- Lets HW agents (key managers, config loaders) program shadowed registers without SW double-write handling.

Parameters:
DW, 32, data width; matches DW of the driven shadowed slice
GapCycles, 0, idle cycles inserted between first and second write (0..15)
CheckReadback, 1, 1: compare qs_i to written data after second write; 0: skip compare (status[1] forced 0)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
req_i  input  1  write request, level; sampled only in IDLE
wdata_i  input  DW  write data, captured on accept
ack_o  output  1  one-cycle pulse, transaction complete
busy_o  output  1  high in every state except IDLE
status_o  output  3  valid with ack_o: [0] update error, [1] readback mismatch, [2] storage error
fatal_o  output  1  sticky storage-error flag, cleared only by reset
re_o  output  1  to slice re (phase clear)
we_o  output  1  to slice we
wd_o  output  DW  to slice wd
err_update_i  input  1  from slice err_update (combinational w.r.t. we_o)
err_storage_i  input  1  from slice err_storage
qs_i  input  DW  from slice qs

Behaviour:
- Clocking and reset:
  - One clock, clk_i. Reset rst_ni is asynchronous and active-low.
  - On reset: state=IDLE; ack_o, busy_o, re_o, we_o, fatal_o = 0; status_o = 0; wd_o = 0; data and gap registers = 0.
- Outputs:
  - re_o/we_o/wd_o are registered-state decodes. wd_o = captured data during WR1/WR2, else 0.
  - we_o and re_o are never high in the same cycle.
- States: IDLE, CLEAR, WR1, GAP, WR2, CHECK, DONE.
  - IDLE: if req_i, capture wdata_i and clear the status accumulator, then go to CLEAR. Else stay.
  - CLEAR: re_o=1 for one cycle to force the slice phase to 0, then WR1.
  - WR1: we_o=1 for one cycle. Next state is GAP if GapCycles>0, else WR2.
  - GAP: 4-bit down-counter loaded with GapCycles-1. Stay while counter!=0, then WR2.
  - WR2: we_o=1. Sample err_update_i in this same cycle into status[0]. Next state CHECK.
  - CHECK: if CheckReadback and qs_i != captured data, set status[1]. Next state DONE.
  - DONE: ack_o=1 and status_o valid for exactly this cycle, then IDLE.
- Latency: accept in cycle 0 gives ack in cycle 5+GapCycles.
- Handshake:
  - req_i is ignored while busy_o=1.
  - A requester holding req_i high through DONE starts a new transaction in the IDLE cycle after DONE. Minimum spacing is 6+GapCycles cycles.
- Storage error:
  - err_storage_i sampled high in any non-IDLE state sets status[2] and fatal_o.
  - The sequencer then aborts directly to DONE with no further re_o/we_o.
  - err_storage_i high in IDLE sets fatal_o only.
  - While fatal_o=1, an accepted request goes IDLE -> DONE with status[2]=1 and no writes.
- err_update_i is ignored outside WR2.
- status_o is 0 in all cycles where ack_o=0.
- Reset mid-transaction returns to IDLE immediately with no ack. The slice shares rst_ni for its phase, so both restart consistent.
- Width rules: compare is full DW bits. The gap counter is 4 bits; a GapCycles value outside 0..15 is an elaboration error.

Test Plan:
- GapCycles=0, req with 0xA5A5_5A5A and a healthy slice -> re_o in cycle 1, we_o in cycles 2 and 3, ack in cycle 5, status=3'b000; slice q=0xA5A5_5A5A.
- GapCycles=3, req with 0x0000_00FF -> we_o in cycles 2 and 6, ack in cycle 8, status=0.
- Force err_update_i=1 during WR2 -> ack with status=3'b001; fatal_o=0. A next clean request succeeds with status=0.
- CheckReadback=1 and qs_i forced to 0x1 while writing 0x2 -> status=3'b010.
- Assert err_storage_i during GAP -> no second we_o, DONE next cycle, status=3'b100, fatal_o=1. A new request acks after 2 cycles with status=3'b100 and no we_o.
- req_i held high continuously, plus rst_ni pulsed low during WR1 -> no ack, all outputs 0. After release, a fresh transaction starts and acks.
